// File: rtl/pdm_interpolator_if.sv
// AXI4-Stream sample channel feeding the PDM interpolator.
// Carries one unsigned NBITS sample per handshake.
interface pdm_interpolator_if #(
  parameter int NBITS = 11
);
  logic [NBITS-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pdm_interpolator.sv
// Linear-ramp interpolator in front of the PDM modulator: one buffered stream
// sample is spread over 2^L clocks, with a starvation (underrun) counter.
module pdm_interpolator #(
  parameter int NBITS      = 11,
  parameter int MAX_LOG2   = 8,
  parameter int UCNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [$clog2(MAX_LOG2+1)-1:0] log2_period,
  pdm_interpolator_if.slave             s_axis,
  output logic [NBITS-1:0]              data_out,
  output logic                          idle,
  output logic [UCNT_WIDTH-1:0]         underrun_count
);

  localparam int LW = $clog2(MAX_LOG2 + 1);
  localparam int AW = NBITS + MAX_LOG2;
  localparam int SW = AW + 1;
  localparam logic [LW-1:0]         MAX_L    = LW'(MAX_LOG2);
  localparam logic [MAX_LOG2-1:0]   CNT_ONE  = MAX_LOG2'(1);
  localparam logic [UCNT_WIDTH-1:0] UCNT_ONE = UCNT_WIDTH'(1);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_t;

  logic [NBITS-1:0]     buf_data;
  logic                 buf_full;
  logic [NBITS-1:0]     target;
  logic [AW-1:0]        acc;
  logic signed [SW-1:0] step;
  logic [MAX_LOG2-1:0]  cnt;
  run_state_t           state, state_nxt;

  logic                 boundary;
  logic                 load;
  logic                 ready;
  logic                 wr;
  logic                 underrun_evt;
  logic [LW-1:0]        l_eff;
  logic [LW-1:0]        shamt;
  logic [MAX_LOG2-1:0]  cnt_reload;
  logic signed [NBITS:0] delta;
  logic signed [SW-1:0] delta_ext;
  logic signed [SW-1:0] step_new;
  logic [SW-1:0]        sum_load;
  logic [SW-1:0]        sum_run;

  // A boundary is the last cycle of a period; the buffer drains only here.
  assign boundary      = (cnt == '0);
  assign load          = boundary && buf_full;
  assign ready         = !buf_full || boundary;
  assign s_axis.tready = ready;
  assign wr            = s_axis.tvalid && ready;
  assign idle          = boundary && !buf_full;

  assign l_eff      = (log2_period > MAX_L) ? MAX_L : log2_period;
  assign shamt      = MAX_L - l_eff;
  assign cnt_reload = ~({MAX_LOG2{1'b1}} << l_eff);

  // Step scaled so that 2^L steps add exactly delta << MAX_LOG2 to acc.
  assign delta     = $signed({1'b0, buf_data}) - $signed({1'b0, target});
  assign delta_ext = {{MAX_LOG2{delta[NBITS]}}, delta};
  assign step_new  = delta_ext <<< shamt;

  assign sum_load = {1'b0, acc} + step_new;
  assign sum_run  = {1'b0, acc} + step;

  // Running/stopped tracking; leaving RUNNING on an empty boundary is an underrun.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_STOPPED;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_nxt    = state;
    underrun_evt = 1'b0;
    case (state)
      ST_STOPPED: begin
        if (load) state_nxt = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (boundary && !buf_full) begin
          state_nxt    = ST_STOPPED;
          underrun_evt = 1'b1;
        end
      end
      default: state_nxt = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the sample buffer is reset too, so a reset drops any pending sample.
      buf_data       <= '0;
      buf_full       <= 1'b0;
      target         <= '0;
      acc            <= '0;
      step           <= '0;
      cnt            <= '0;
      data_out       <= '0;
      underrun_count <= '0;
    end else begin
      data_out <= acc[AW-1:MAX_LOG2];

      if (load) begin
        step   <= step_new;
        acc    <= sum_load[AW-1:0];
        cnt    <= cnt_reload;
        target <= buf_data;
      end else if (!boundary) begin
        acc <= sum_run[AW-1:0];
        cnt <= cnt - CNT_ONE;
      end

      if (wr) begin
        buf_data <= s_axis.tdata;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end

      if (underrun_evt && !(&underrun_count)) begin
        underrun_count <= underrun_count + UCNT_ONE;
      end
    end
  end

  // Ramps stay between in-range endpoints, so the accumulator never wraps.
  a_load_in_range : assert property (@(posedge clk) disable iff (!resetn)
    load |-> !sum_load[SW-1]);
  a_run_in_range : assert property (@(posedge clk) disable iff (!resetn)
    !boundary |-> !sum_run[SW-1]);

endmodule
